imem_load_run_ctrl: RTL and testbench
=====================================

Name: imem_load_run_ctrl

Overview:
- Sequencer that brings up the Mips16 pipeline in order: load the instruction memory, reset the PC, run, then drain.
- Accepts a valid/ready word stream from a host or testbench and converts it into the core's din/wen write strobes.
- Issues a single-cycle pc_reset, holds rd_en for a programmed number of cycles (or until stopped), then waits a fixed drain time so in-flight instructions retire through WB.
- Sits between the host/bench and the core's din, wen, pc_reset and rd_en inputs.

Parameters:
- IMEM_DEPTH, 256, number of instruction words the IM can hold.
- CNT_W, 9, width of the word counter (must hold 0..IMEM_DEPTH).
- DRAIN_CYCLES, 5, idle cycles after run so IF..WB empties (five pipeline stages).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous and active-low.
- load_start  in  1  one-cycle pulse; begins a load from IDLE.
- host_data  in  16  instruction word offered by the host.
- host_valid  in  1  host_data is valid.
- host_last  in  1  marks the final word; qualified by host_valid.
- host_ready  out  1  block accepts a word this cycle.
- run_start  in  1  pulse; begins execution from ARMED.
- run_len  in  16  cycles to hold rd_en; 0 means unbounded. Sampled on run_start.
- run_stop  in  1  ends RUN early.
- abort  in  1  return to IDLE from any state.
- din  out  16  registered instruction word to the core.
- wen  out  1  registered IM write strobe.
- pc_reset  out  1  single-cycle PC reset.
- rd_en  out  1  instruction-fetch enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when DRAIN completes.
- overflow  out  1  sticky; load hit IMEM_DEPTH without host_last.
- words_loaded  out  CNT_W  number of words accepted in the current or last load.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. All outputs are 0, including din, words_loaded and overflow.
- States: IDLE=0, LOAD=1, PCRST=2, ARMED=3, RUN=4, DRAIN=5.
- IDLE:
  - load_start moves to LOAD.
  - On entry to LOAD: words_loaded clears to 0 and overflow clears.
  - run_start is ignored in IDLE.
- LOAD:
  - host_ready = (words_loaded < IMEM_DEPTH). It is combinational from state and the counter.
  - A word is accepted when host_valid and host_ready are both high.
  - One accepted word produces din=host_data and wen=1 on the following cycle (latency 1). wen is 0 otherwise.
  - words_loaded increments on each accept.
  - Accepting with host_last moves to PCRST.
  - If words_loaded reaches IMEM_DEPTH without host_last, overflow is set and the block moves to PCRST.
  - No further words are accepted once IMEM_DEPTH is reached.
- PCRST:
  - pc_reset=1 for exactly this one cycle. This coincides with the final wen pulse, because that pulse is registered.
  - Next state is ARMED.
- ARMED:
  - Waits for run_start.
  - On run_start: run_len is latched into the run counter and the block moves to RUN.
  - load_start in ARMED starts a new LOAD (reload without running).
- RUN:
  - rd_en=1 in every RUN cycle.
  - When latched run_len≠0, the block leaves RUN after exactly run_len rd_en cycles.
  - When latched run_len=0, it stays in RUN until run_stop.
  - run_stop exits RUN after the current cycle, even if the counter has not expired.
  - Counter expiry and run_stop in the same cycle: a single exit; no special handling.
  - Exit goes to DRAIN.
- DRAIN:
  - rd_en=0 for DRAIN_CYCLES cycles.
  - done pulses in the last DRAIN cycle.
  - Next state is IDLE.
- abort has priority over every transition. The next state is IDLE and wen/pc_reset/rd_en are deasserted on the next edge; no done pulse is produced.
- words_loaded and overflow are kept after abort and after the run, until the next load_start.
- Simultaneous load_start and run_start in ARMED: load_start wins.
- Counters: words_loaded saturates at IMEM_DEPTH. The run counter is 16-bit and never wraps, because it is only loaded when the value is nonzero.

Decomposition:
- Shared package (mips16_pkg) holds:
  - the state encoding constants;
  - the WORD_W=16 constant;
  - the DRAIN_CYCLES default, so it matches the pipeline depth.
- One natural sub-module, cycle_counter: a loadable down-counter with terminal-count flag. It is instantiated twice, once for the run length and once for the drain.
- Word counting stays inline.

Test Plan:
- Load 3 words (0x2001, 0x4082, 0x0000 with host_last), host_valid held high:
  - wen high for 3 consecutive cycles, one cycle after each accept, with din matching each word;
  - pc_reset high for exactly 1 cycle, aligned with the third wen;
  - words_loaded=3, overflow=0, state=ARMED.
- run_start with run_len=10:
  - rd_en high for exactly 10 cycles;
  - then 5 cycles low;
  - done pulses once; state returns to IDLE.
- With IMEM_DEPTH=4, stream 6 words and never assert host_last:
  - only 4 accepted; host_ready drops after the 4th;
  - overflow=1; transition to PCRST.
- run_len=0, then run_stop after 37 cycles: rd_en high for 37 cycles, then DRAIN and done.
- Assert abort in the middle of LOAD, and separately in the middle of RUN:
  - next cycle state=IDLE and wen=rd_en=pc_reset=0;
  - no done pulse;
  - a subsequent load_start resets words_loaded.
- Pull reset low mid-RUN, asynchronously between clock edges: all outputs go to 0 immediately and state=IDLE.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared constants for the Mips16 bring-up sequencer: state encoding, word width
// and the drain length that matches the five-stage pipeline.
package mips16_pkg;
  localparam int WORD_W           = 16;
  localparam int DRAIN_CYCLES_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PCRST = 3'd2,
    S_ARMED = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
endpackage

// File: rtl/imem_load_run_ctrl_cycle_counter.sv
// Loadable down-counter; stops at zero and flags terminal count while at zero.
module cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (load)              count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  end

  assign tc = (count == '0);
endmodule

// File: rtl/imem_load_run_ctrl.sv
// Bring-up sequencer for the Mips16 core: streams words into IM, pulses pc_reset,
// holds rd_en for a programmed length, then drains the pipeline.
module imem_load_run_ctrl
  import mips16_pkg::*;
#(
  parameter int IMEM_DEPTH   = 256,
  parameter int CNT_W        = 9,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [WORD_W-1:0] host_data,
  input  logic              host_valid,
  input  logic              host_last,
  output logic              host_ready,
  input  logic              run_start,
  input  logic [15:0]       run_len,
  input  logic              run_stop,
  input  logic              abort,
  output logic [WORD_W-1:0] din,
  output logic              wen,
  output logic              pc_reset,
  output logic              rd_en,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  words_loaded,
  output logic [2:0]        state
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IMEM_DEPTH);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t st, st_nxt;
  logic accept, at_limit, go_load, go_run, run_exit, run_inf;
  logic [15:0]        run_cnt;
  logic               run_tc;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_tc;

  // abort blocks the handshake so an aborted word is never half-consumed
  assign host_ready = (st == S_LOAD) && (words_loaded < DEPTH_C) && !abort;
  assign accept     = host_valid && host_ready;
  assign at_limit   = (words_loaded == DEPTH_C - CNT_W'(1));
  assign go_load    = load_start && (st == S_IDLE || st == S_ARMED) && !abort;
  assign go_run     = run_start && !load_start && (st == S_ARMED) && !abort;
  assign run_exit   = (st == S_RUN) && (run_stop || (!run_inf && run_tc));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (load_start) st_nxt = S_LOAD;
      S_LOAD:  if (accept && (host_last || at_limit)) st_nxt = S_PCRST;
      S_PCRST: st_nxt = S_ARMED;
      S_ARMED: begin
        if (load_start)     st_nxt = S_LOAD;
        else if (run_start) st_nxt = S_RUN;
      end
      S_RUN:   if (run_exit) st_nxt = S_DRAIN;
      S_DRAIN: if (drain_tc) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
    if (abort) st_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din          <= '0;
      wen          <= 1'b0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      run_inf      <= 1'b0;
    end else begin
      wen <= accept;
      if (accept) din <= host_data;
      if (go_load) begin
        words_loaded <= '0;
        overflow     <= 1'b0;
      end else if (accept) begin
        words_loaded <= words_loaded + CNT_W'(1);
        if (at_limit && !host_last) overflow <= 1'b1;
      end
      if (go_run) run_inf <= (run_len == 16'd0);
    end
  end

  // Loaded with len-1 so terminal count lands on the last rd_en cycle;
  // a zero length never loads, so the counter cannot wrap.
  cycle_counter #(.W(16)) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (go_run && run_len != 16'd0),
    .load_val (run_len - 16'd1),
    .dec      (st == S_RUN),
    .count    (run_cnt),
    .tc       (run_tc)
  );

  cycle_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (run_exit),
    .load_val (DRAIN_W'(DRAIN_CYCLES - 1)),
    .dec      (st == S_DRAIN),
    .count    (drain_cnt),
    .tc       (drain_tc)
  );

  assign pc_reset = (st == S_PCRST);
  assign rd_en    = (st == S_RUN);
  assign busy     = (st != S_IDLE);
  assign done     = (st == S_DRAIN) && drain_tc && !abort;
  assign state    = st;
endmodule

// File: tb/tb_imem_load_run_ctrl.sv
// Randomised bench for imem_load_run_ctrl with a list-level model of load and run.
module tb_imem_load_run_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 9;
  localparam int DRAIN = 5;

  logic        clk = 1'b0, reset = 1'b0;
  logic        load_start = 0, host_valid = 0, host_last = 0, host_ready;
  logic [15:0] host_data = '0, run_len = '0, din;
  logic        run_start = 0, run_stop = 0, abort = 0;
  logic        wen, pc_reset, rd_en, busy, done, overflow;
  logic [CNT_W-1:0] words_loaded;
  logic [2:0]  state;

  imem_load_run_ctrl #(.IMEM_DEPTH(DEPTH), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .host_data(host_data),
    .host_valid(host_valid), .host_last(host_last), .host_ready(host_ready),
    .run_start(run_start), .run_len(run_len), .run_stop(run_stop), .abort(abort),
    .din(din), .wen(wen), .pc_reset(pc_reset), .rd_en(rd_en), .busy(busy),
    .done(done), .overflow(overflow), .words_loaded(words_loaded), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] wr_q[$];
  int wen_cyc[$];
  int pcr_n, pcr_wen, rd_n, last_rd_cyc, done_n, done_cyc;

  always @(negedge clk) begin
    if (wen === 1'b1) begin wr_q.push_back(din); wen_cyc.push_back(cyc); end
    if (pc_reset === 1'b1) begin pcr_n++; pcr_wen = (wen === 1'b1); end
    if (rd_en === 1'b1) begin rd_n++; last_rd_cyc = cyc; end
    if (done === 1'b1) begin done_n++; done_cyc = cyc; end
  end

  logic [15:0] wbuf[8];
  int  wn, vpct;
  bit  wlast;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic clr_mon;
    wr_q.delete(); wen_cyc.delete();
    pcr_n = 0; pcr_wen = 0; rd_n = 0; last_rd_cyc = 0; done_n = 0; done_cyc = 0;
  endtask

  task automatic drive_load;
    int idx, budget;
    bit a;
    load_start = 1; tick; load_start = 0;
    idx = 0; budget = 0;
    while (state == 3'd1 && idx < wn && budget < 200) begin
      host_valid = ($urandom_range(99) < vpct);
      host_data  = wbuf[idx];
      host_last  = wlast && (idx == wn - 1);
      @(negedge clk); a = host_valid && host_ready;
      tick;
      if (a) idx++;
      budget++;
    end
    host_valid = 0; host_last = 0;
  endtask

  // Expected: accepted words are the first min(wn,DEPTH) offered; overflow unless
  // host_last arrived within capacity.
  task automatic check_load(input string nm);
    int exp_k;
    bit exp_ovf;
    exp_k   = (wn < DEPTH) ? wn : DEPTH;
    exp_ovf = !(wlast && wn <= DEPTH);
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL %s pcrst_state: got %0d expected 2", nm, state); end
    n_tests++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_drop: got %b expected 0", nm, host_ready); end
    tick;
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL %s armed: got %0d expected 3", nm, state); end
    n_tests++; if (words_loaded !== CNT_W'(exp_k)) begin n_fail++; $display("FAIL %s words_loaded: got %0d expected %0d", nm, words_loaded, exp_k); end
    n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL %s overflow: got %b expected %b", nm, overflow, exp_ovf); end
    n_tests++; if (pcr_n != 1 || pcr_wen != 1) begin n_fail++; $display("FAIL %s pc_reset: got count %0d with_wen %0d expected 1 1", nm, pcr_n, pcr_wen); end
    n_tests++; if (wr_q.size() != exp_k) begin n_fail++; $display("FAIL %s wen_count: got %0d expected %0d", nm, wr_q.size(), exp_k); end
    for (int i = 0; i < exp_k && i < wr_q.size(); i++) begin
      n_tests++; if (wr_q[i] !== wbuf[i]) begin n_fail++; $display("FAIL %s din[%0d]: got %h expected %h", nm, i, wr_q[i], wbuf[i]); end
    end
  endtask

  task automatic run_seq(input int len, input int stop_at, input string nm);
    int k, b, exp_rd;
    clr_mon;
    run_len = 16'(len); run_start = 1; tick; run_start = 0;
    k = 1;
    while (state == 3'd4 && k < 300) begin
      if (k == stop_at) run_stop = 1;
      tick; run_stop = 0; k++;
    end
    b = 0;
    while (state != 3'd0 && b < 50) begin tick; b++; end
    exp_rd = (len == 0) ? stop_at : ((stop_at > 0 && stop_at < len) ? stop_at : len);
    n_tests++; if (rd_n != exp_rd) begin n_fail++; $display("FAIL %s rd_cycles: got %0d expected %0d", nm, rd_n, exp_rd); end
    n_tests++; if (done_n != 1) begin n_fail++; $display("FAIL %s done_count: got %0d expected 1", nm, done_n); end
    n_tests++; if (done_cyc - last_rd_cyc != DRAIN) begin n_fail++; $display("FAIL %s drain_gap: got %0d expected %0d", nm, done_cyc - last_rd_cyc, DRAIN); end
    n_tests++; if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s idle: got state %0d busy %b expected 0 0", nm, state, busy); end
  endtask

  task automatic quick_load(input logic [15:0] w);
    wbuf[0] = w; wn = 1; wlast = 1; vpct = 100;
    clr_mon; drive_load; tick;
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if ({din, wen, pc_reset, rd_en, busy, done, overflow, host_ready} !== '0 || words_loaded !== '0 || state !== 3'd0) begin
      n_fail++; $display("FAIL reset_outputs: got din %h wen %b state %0d wl %0d expected all 0", din, wen, state, words_loaded); end
    tick; tick; reset = 1; tick;
    run_start = 1; run_len = 16'd3; tick; run_start = 0;
    n_tests++; if (state !== 3'd0 || rd_en !== 1'b0) begin n_fail++; $display("FAIL run_in_idle: got state %0d expected 0", state); end
  endtask

  task automatic test_load_basic;
    wbuf[0] = 16'h2001; wbuf[1] = 16'h4082; wbuf[2] = 16'h0000;
    wn = 3; wlast = 1; vpct = 100;
    clr_mon; drive_load;
    check_load("basic");
    n_tests++; if (wen_cyc.size() != 3 || wen_cyc[2] - wen_cyc[0] != 2) begin n_fail++; $display("FAIL basic_wen_consecutive: got %0d strobes expected 3 back to back", wen_cyc.size()); end
  endtask

  task automatic test_run_bounded;
    run_seq(10, 0, "run10");
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 6; i++) wbuf[i] = 16'h1000 + 16'(i);
    wn = 6; wlast = 0; vpct = 100;
    clr_mon; drive_load;
    check_load("overflow");
    run_seq(2, 0, "ovf_run");
  endtask

  task automatic test_run_unbounded;
    quick_load(16'hABCD);
    run_seq(0, 37, "run_stop37");
  endtask

  task automatic test_armed_reload;
    quick_load(16'h5555);
    load_start = 1; run_start = 1; run_len = 16'd4; tick; load_start = 0; run_start = 0;
    n_tests++; if (state !== 3'd1 || words_loaded !== '0) begin n_fail++; $display("FAIL reload_wins: got state %0d wl %0d expected 1 0", state, words_loaded); end
    wbuf[0] = 16'h7001; wbuf[1] = 16'h7002; wn = 2; wlast = 1; vpct = 100;
    clr_mon; drive_load;
    check_load("reload");
    run_seq(1, 0, "run1");
  endtask

  task automatic test_abort_load;
    clr_mon;
    load_start = 1; tick; load_start = 0;
    host_valid = 1; host_data = 16'h1111; tick;
    host_data = 16'h2222; tick;
    abort = 1; host_data = 16'h3333; tick; abort = 0; host_valid = 0;
    n_tests++; if (state !== 3'd0 || wen !== 1'b0 || rd_en !== 1'b0 || pc_reset !== 1'b0) begin n_fail++; $display("FAIL abort_load: got state %0d wen %b expected 0 0", state, wen); end
    n_tests++; if (words_loaded !== CNT_W'(2)) begin n_fail++; $display("FAIL abort_load_kept: got %0d expected 2", words_loaded); end
    repeat (10) tick;
    n_tests++; if (done_n != 0 || pcr_n != 0) begin n_fail++; $display("FAIL abort_load_nodone: got done %0d pcr %0d expected 0 0", done_n, pcr_n); end
    load_start = 1; tick; load_start = 0;
    n_tests++; if (words_loaded !== '0 || state !== 3'd1) begin n_fail++; $display("FAIL abort_reload_clear: got wl %0d state %0d expected 0 1", words_loaded, state); end
    abort = 1; tick; abort = 0;
  endtask

  task automatic test_abort_run;
    quick_load(16'h0F0F);
    clr_mon;
    run_len = 16'd0; run_start = 1; tick; run_start = 0;
    repeat (5) tick;
    abort = 1; tick; abort = 0;
    n_tests++; if (state !== 3'd0 || rd_en !== 1'b0 || wen !== 1'b0 || pc_reset !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_run: got state %0d rd_en %b expected 0 0", state, rd_en); end
    repeat (12) tick;
    n_tests++; if (done_n != 0) begin n_fail++; $display("FAIL abort_run_nodone: got %0d expected 0", done_n); end
    n_tests++; if (words_loaded !== CNT_W'(1)) begin n_fail++; $display("FAIL abort_run_kept: got %0d expected 1", words_loaded); end
  endtask

  task automatic test_async_reset;
    quick_load(16'hBEEF);
    run_len = 16'd0; run_start = 1; tick; run_start = 0;
    repeat (3) tick;
    #2 reset = 0;
    #1;
    n_tests++; if (state !== 3'd0 || rd_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_state: got state %0d rd_en %b expected 0 0", state, rd_en); end
    n_tests++; if (din !== '0 || words_loaded !== '0 || overflow !== 1'b0 || wen !== 1'b0 || pc_reset !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: got din %h wl %0d expected 0 0", din, words_loaded); end
    tick; reset = 1; tick;
  endtask

  task automatic test_random;
    int len, stop;
    for (int it = 0; it < 10; it++) begin
      wn = $urandom_range(1, 6);
      wlast = ($urandom_range(0, 3) != 0);
      if (!wlast) wn = 6;
      vpct = $urandom_range(40, 100);
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      clr_mon; drive_load;
      check_load($sformatf("rand%0d", it));
      len = $urandom_range(0, 12);
      if (len == 0) stop = $urandom_range(1, 15);
      else stop = ($urandom_range(0, 1) != 0) ? $urandom_range(1, len + 3) : 0;
      run_seq(len, stop, $sformatf("rand_run%0d", it));
    end
  endtask

  initial begin
    test_reset;
    test_load_basic;
    test_run_bounded;
    test_overflow;
    test_run_unbounded;
    test_armed_reload;
    test_abort_load;
    test_abort_run;
    test_async_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule
